// File: rtl/ser_rom_seq.sv
// Bus-side sequencer for a 93xx serial EEPROM in x8 mode. A CPU read of the serial window is
// stalled while a Microwire READ fetches the byte. The last byte fetched is held in a one-entry cache.
module ser_rom_seq #(
   parameter int unsigned SK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       SSER,
   input  logic       BA13,
   input  logic       BA12,
   input  logic [3:0] BA,
   input  logic       BR_W,
   output logic [7:0] SDRD,
   output logic       WAIT,
   output logic       ERR,
   output logic       SCS,
   output logic       SSK,
   output logic       SDI,
   input  logic       SDO
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      CMD,
      DUMMY,
      DATA,
      DONE,
      GAP
   } state_t;

   localparam logic [7:0] DivLast = 8'(SK_DIV - 1);

   state_t     state_q, state_d;
   logic [7:0] divCnt_q, divCnt_d;
   logic       phase_q, phase_d;
   logic [3:0] bitCnt_q, bitCnt_d;
   logic [3:0] areg_q, areg_d;
   logic [7:0] shift_q, shift_d;
   logic       vld_q, vld_d;
   logic [3:0] tag_q, tag_d;
   logic [7:0] dat_q, dat_d;
   logic       err_q, err_d;
   logic       dummyBad_q, dummyBad_d;
   logic       sdoMeta_q, sdoSync_q;

   logic       winRd;
   logic       hit;
   logic       idleHit;
   logic       halfEnd;
   logic       inBit;
   logic [9:0] cmdWord;

   assign winRd   = ~SSER & ~BA13 & BA12 & BR_W;
   assign hit     = vld_q & (tag_q == BA);
   assign idleHit = hit & (state_q == IDLE);
   assign halfEnd = (divCnt_q == DivLast);
   assign inBit   = (state_q == CMD) | (state_q == DUMMY) | (state_q == DATA);
   assign cmdWord = {3'b110, 3'b000, areg_q};

   assign SDRD = (winRd & idleHit) ? dat_q : 8'h00;
   assign WAIT = winRd & ~idleHit;
   assign ERR  = err_q;
   assign SCS  = (state_q == START) | inBit;
   assign SSK  = inBit & phase_q;
   assign SDI  = (state_q == CMD) & cmdWord[4'd9 - bitCnt_q];

   // SDO comes from another device's clock domain relative to our sampling point
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sdoMeta_q <= 1'b0;
         sdoSync_q <= 1'b0;
      end else begin
         sdoMeta_q <= SDO;
         sdoSync_q <= sdoMeta_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         divCnt_q   <= 8'd0;
         phase_q    <= 1'b0;
         bitCnt_q   <= 4'd0;
         areg_q     <= 4'd0;
         shift_q    <= 8'd0;
         vld_q      <= 1'b0;
         tag_q      <= 4'd0;
         dat_q      <= 8'd0;
         err_q      <= 1'b0;
         dummyBad_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         divCnt_q   <= divCnt_d;
         phase_q    <= phase_d;
         bitCnt_q   <= bitCnt_d;
         areg_q     <= areg_d;
         shift_q    <= shift_d;
         vld_q      <= vld_d;
         tag_q      <= tag_d;
         dat_q      <= dat_d;
         err_q      <= err_d;
         dummyBad_q <= dummyBad_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      divCnt_d   = divCnt_q;
      phase_d    = phase_q;
      bitCnt_d   = bitCnt_q;
      areg_d     = areg_q;
      shift_d    = shift_q;
      vld_d      = vld_q;
      tag_d      = tag_q;
      dat_d      = dat_q;
      err_d      = err_q;
      dummyBad_d = dummyBad_q;

      case (state_q)
         IDLE: begin
            if (winRd && !hit) begin
               areg_d     = BA;
               dummyBad_d = 1'b0;
               divCnt_d   = 8'd0;
               state_d    = START;
            end
         end

         START: begin
            if (halfEnd) begin
               divCnt_d = 8'd0;
               phase_d  = 1'b0;
               bitCnt_d = 4'd0;
               state_d  = CMD;
            end else begin
               divCnt_d = divCnt_q + 8'd1;
            end
         end

         // Each bit is a low half then a high half; the device output is sampled as SK rises
         CMD, DUMMY, DATA: begin
            if (!halfEnd) begin
               divCnt_d = divCnt_q + 8'd1;
            end else begin
               divCnt_d = 8'd0;
               if (!phase_q) begin
                  phase_d = 1'b1;
                  if (state_q == DUMMY && sdoSync_q) begin
                     dummyBad_d = 1'b1;
                     err_d      = 1'b1;
                  end
                  if (state_q == DATA) begin
                     shift_d = {shift_q[6:0], sdoSync_q};
                  end
               end else begin
                  phase_d = 1'b0;
                  if (state_q == CMD) begin
                     if (bitCnt_q == 4'd9) begin
                        bitCnt_d = 4'd0;
                        state_d  = DUMMY;
                     end else begin
                        bitCnt_d = bitCnt_q + 4'd1;
                     end
                  end else if (state_q == DUMMY) begin
                     bitCnt_d = 4'd0;
                     state_d  = DATA;
                  end else begin
                     if (bitCnt_q == 4'd7) begin
                        state_d = DONE;
                     end else begin
                        bitCnt_d = bitCnt_q + 4'd1;
                     end
                  end
               end
            end
         end

         DONE: begin
            dat_d    = shift_q;
            tag_d    = areg_q;
            vld_d    = ~dummyBad_q;
            divCnt_d = 8'd0;
            state_d  = GAP;
         end

         GAP: begin
            if (halfEnd) begin
               divCnt_d = 8'd0;
               state_d  = IDLE;
            end else begin
               divCnt_d = divCnt_q + 8'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ser_rom_seq.sv
// Bench for ser_rom_seq: a Microwire EEPROM device model, a cycle-count reference model of the
// CPU-visible behaviour compared every cycle, and directed reads with hand-computed results.
module tb_ser_rom_seq;

   localparam int SkDiv     = 2;
   localparam int TxnCycles = 40 * SkDiv + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       SSER, BA13, BA12, BR_W, SDO;
   logic [3:0] BA;
   logic [7:0] SDRD;
   logic       WAIT, ERR, SCS, SSK, SDI;

   int checks   = 0;
   int failures = 0;

   logic [7:0] romData  [16];
   logic       romDummy [16];

   ser_rom_seq #(.SK_DIV(SkDiv)) dut (
      .clk (clk),
      .rst (rst),
      .SSER(SSER),
      .BA13(BA13),
      .BA12(BA12),
      .BA  (BA),
      .BR_W(BR_W),
      .SDRD(SDRD),
      .WAIT(WAIT),
      .ERR (ERR),
      .SCS (SCS),
      .SSK (SSK),
      .SDI (SDI),
      .SDO (SDO)
   );

   always #5 clk = ~clk;

   function automatic logic winRd();
      return ~SSER & ~BA13 & BA12 & BR_W;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // EEPROM device: latches DI on SK rise, then drives the dummy 0 and D7..D0 after successive rises
   int         riseCnt = 0;
   logic       prevSsk = 1'b0;
   logic [9:0] cmdShift = 10'd0;
   logic [9:0] lastCmd = 10'd0;

   always @(posedge clk) begin
      #1;
      if (!SCS) begin
         riseCnt = 0;
         SDO     = 1'b0;
      end else if (SSK && !prevSsk) begin
         riseCnt++;
         if (riseCnt <= 10) cmdShift = {cmdShift[8:0], SDI};
         if (riseCnt == 10) begin
            lastCmd = cmdShift;
            SDO     = romDummy[cmdShift[3:0]];
         end else if (riseCnt >= 11 && riseCnt <= 18) begin
            SDO = romData[cmdShift[3:0]][18 - riseCnt];
         end else begin
            SDO = 1'b0;
         end
      end
      prevSsk = SSK;
   end

   // Reference model: a miss costs a fixed number of busy cycles, after which the cache holds the word
   int         mBusy = 0;
   logic       mVld = 1'b0;
   logic [3:0] mTag = 4'd0, mPendTag = 4'd0;
   logic [7:0] mDat = 8'd0, mPendDat = 8'd0;
   logic       mErr = 1'b0, mPendErr = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mBusy = 0;
         mVld  = 1'b0;
         mTag  = 4'd0;
         mDat  = 8'd0;
         mErr  = 1'b0;
      end else if (mBusy > 0) begin
         if (mBusy == SkDiv + 1) begin
            mTag = mPendTag;
            mDat = mPendDat;
            mVld = ~mPendErr;
            mErr = mErr | mPendErr;
         end
         mBusy--;
      end else if (winRd() && !(mVld && mTag == BA)) begin
         mBusy    = TxnCycles;
         mPendTag = BA;
         mPendDat = romData[BA];
         mPendErr = romDummy[BA];
      end
   end

   int   scsRises = 0;
   logic prevScs  = 1'b0;
   logic hitNow, scsExp;

   always @(negedge clk) begin
      hitNow = (mBusy == 0) && mVld && (mTag == BA);
      scsExp = (mBusy > SkDiv + 1);
      checkOutput("wait", 32'(WAIT), 32'(winRd() && !hitNow));
      checkOutput("sdrd", 32'(SDRD), 32'((winRd() && hitNow) ? mDat : 8'h00));
      checkOutput("scs", 32'(SCS), 32'(scsExp));
      if (!scsExp) checkOutput("ssk_idle", 32'(SSK), 32'(1'b0));
      if (mBusy == 0) checkOutput("err", 32'(ERR), 32'(mErr));
      if (SCS && !prevScs) scsRises++;
      prevScs = SCS;
   end

   task automatic applyStimulus(input logic [3:0] ba, output logic [7:0] data,
                                output int waitCycles, output int txns);
      int startRises;
      bit done;
      @(posedge clk);
      #1;
      SSER = 1'b0; BA13 = 1'b0; BA12 = 1'b1; BR_W = 1'b1; BA = ba;
      startRises = scsRises;
      waitCycles = 0;
      done       = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (!WAIT) done = 1'b1;
         else waitCycles++;
      end
      checkOutput("wait_bound", 32'(done), 32'(1'b1));
      data = SDRD;
      txns = scsRises - startRises;
      @(posedge clk);
      #1;
      SSER = 1'b1;
   endtask

   logic [7:0] rdData;
   int         rdWait, rdTxns, startRises;

   initial begin
      rst = 1'b1; SSER = 1'b1; BA13 = 1'b0; BA12 = 1'b0; BR_W = 1'b1; BA = 4'd0; SDO = 1'b0;
      for (int i = 0; i < 16; i++) begin
         romData[i]  = 8'(i * 17 + 3);
         romDummy[i] = 1'b0;
      end
      romData[5]  = 8'hA7;
      romData[9]  = 8'h3C;
      romData[2]  = 8'h55;
      romDummy[2] = 1'b1;

      repeat (2) @(negedge clk);
      checkOutput("rst_scs", 32'(SCS), 32'(0));
      checkOutput("rst_ssk", 32'(SSK), 32'(0));
      checkOutput("rst_sdi", 32'(SDI), 32'(0));
      checkOutput("rst_err", 32'(ERR), 32'(0));
      checkOutput("rst_sdrd", 32'(SDRD), 32'(0));
      @(posedge clk);
      #1 rst = 1'b0;

      $display("[TB] first read of word 5");
      applyStimulus(4'h5, rdData, rdWait, rdTxns);
      checkOutput("t1_sdi_seq", 32'(lastCmd), 32'(10'b1100000101));
      // rdWait includes the IDLE cycle in which the miss is seen
      checkOutput("t1_stall_after_miss", 32'(rdWait - 1), 32'd81);
      checkOutput("t1_sdrd", 32'(rdData), 32'h0A7);
      checkOutput("t1_txns", 32'(rdTxns), 32'd1);
      checkOutput("t1_err", 32'(ERR), 32'd0);

      $display("[TB] cached read of word 5");
      applyStimulus(4'h5, rdData, rdWait, rdTxns);
      checkOutput("t2_wait", 32'(rdWait), 32'd0);
      checkOutput("t2_sdrd", 32'(rdData), 32'h0A7);
      checkOutput("t2_txns", 32'(rdTxns), 32'd0);

      $display("[TB] read word 9 then word 5");
      applyStimulus(4'h9, rdData, rdWait, rdTxns);
      checkOutput("t3_sdrd9", 32'(rdData), 32'h03C);
      checkOutput("t3_txns9", 32'(rdTxns), 32'd1);
      applyStimulus(4'h5, rdData, rdWait, rdTxns);
      checkOutput("t3_sdrd5", 32'(rdData), 32'h0A7);
      checkOutput("t3_txns5", 32'(rdTxns), 32'd1);
      applyStimulus(4'h5, rdData, rdWait, rdTxns);
      checkOutput("t3_tag5_hit", 32'(rdTxns), 32'd0);

      $display("[TB] dummy bit error on word 2");
      @(posedge clk);
      #1;
      SSER = 1'b0; BA13 = 1'b0; BA12 = 1'b1; BR_W = 1'b1; BA = 4'h2;
      startRises = scsRises;
      for (int i = 0; i < 400 && (scsRises - startRises) < 2; i++) @(negedge clk);
      checkOutput("t4_retry_txn", 32'(scsRises - startRises), 32'd2);
      checkOutput("t4_err_set", 32'(ERR), 32'd1);
      @(posedge clk);
      #1 SSER = 1'b1;
      repeat (100) @(negedge clk);
      checkOutput("t4_err_sticky", 32'(ERR), 32'd1);

      $display("[TB] reset during data bit 3");
      @(posedge clk);
      #1;
      SSER = 1'b0; BA = 4'h9;
      for (int i = 0; i < 400 && riseCnt < 15; i++) @(negedge clk);
      checkOutput("t5_reached_bit3", 32'(riseCnt), 32'd15);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("t5_scs", 32'(SCS), 32'd0);
      checkOutput("t5_ssk", 32'(SSK), 32'd0);
      checkOutput("t5_sdrd", 32'(SDRD), 32'd0);
      SSER = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      applyStimulus(4'h5, rdData, rdWait, rdTxns);
      checkOutput("t5_txns", 32'(rdTxns), 32'd1);
      checkOutput("t5_stall_after_miss", 32'(rdWait - 1), 32'd81);
      checkOutput("t5_sdrd_after", 32'(rdData), 32'h0A7);

      $display("[TB] window write and BA13 access");
      @(posedge clk);
      #1;
      SSER = 1'b0; BA13 = 1'b0; BA12 = 1'b1; BR_W = 1'b0; BA = 4'h5;
      startRises = scsRises;
      repeat (10) begin
         @(negedge clk);
         checkOutput("t6_wr_wait", 32'(WAIT), 32'd0);
         checkOutput("t6_wr_sdrd", 32'(SDRD), 32'd0);
      end
      @(posedge clk);
      #1;
      BR_W = 1'b1; BA13 = 1'b1;
      repeat (10) begin
         @(negedge clk);
         checkOutput("t6_ba13_wait", 32'(WAIT), 32'd0);
         checkOutput("t6_ba13_sdrd", 32'(SDRD), 32'd0);
      end
      checkOutput("t6_no_scs", 32'(scsRises - startRises), 32'd0);
      @(posedge clk);
      #1 SSER = 1'b1;

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

endmodule

// File: doc/ser_rom_seq.md
# ser_rom_seq

Bus-side sequencer for the 93xx-family serial configuration EEPROM in x8 organisation. It decodes CPU reads of the serial window (SSER low, BA13 low, BA12 high, BR_W high), stalls the CPU with WAIT, and runs a Microwire READ of word `{3'b000, BA[7:4]}`. It returns the byte on SDRD and keeps a one-entry cache, so repeated reads of the same word complete without a serial transaction. It replaces the ad-hoc registered PAL sequencing on the serial-read path.

## Interface
Parameters:
- SK_DIV, 2, clk cycles per SK half-period; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- SSER  in  1  serial-window select, active low
- BA13  in  1  bus address bit 13; must be 0 for a window hit
- BA12  in  1  bus address bit 12; must be 1 for a window hit
- BA  in  4  bus address bits 7..4; the EEPROM word address
- BR_W  in  1  1 = read cycle, 0 = write cycle
- SDRD  out  8  read data to bus; 0 when no hit is being served
- WAIT  out  1  CPU stall request
- ERR  out  1  sticky dummy-bit error flag
- SCS  out  1  EEPROM chip select, active high
- SSK  out  1  EEPROM serial clock
- SDI  out  1  EEPROM data-in (to the device)
- SDO  in  1  EEPROM data-out; synchronised internally through 2 flops

## Operation
- Window read (win_rd) = ~SSER & ~BA13 & BA12 & BR_W.
  - Writes to the window (BR_W = 0) are ignored.
  - Accesses outside the window are ignored.
- Cache consists of vld, tag[3:0] and dat[7:0].
  - hit = vld & (tag == BA).
- Combinational outputs:
  - SDRD = (win_rd & hit & state==IDLE) ? dat : 8'h00.
  - WAIT = win_rd & ~(hit & state==IDLE).
- States: IDLE, START, CMD, DUMMY, DATA, DONE, GAP.
  - IDLE: on win_rd & ~hit, latch BA into areg and go to START. Hold otherwise.
  - START: SCS=1, SSK=0, SDI=0 for SK_DIV cycles, then CMD.
  - CMD: shift 10 bits MSB first: 1, 1, 0, then A6..A0 = {000, areg}. Then DUMMY.
  - DUMMY: one bit with SDI=0. Synchronised SDO sampled at SK rise must be 0. If it is 1, set ERR. Then DATA.
  - DATA: 8 bits, D7 first, shifted into a shift register at each SK rise. SDI=0.
  - DONE (1 cycle):
    - SCS=0.
    - dat <= shift register, tag <= areg.
    - vld <= 1, unless the DUMMY check failed in this transaction; then vld <= 0.
    - Go to GAP.
  - GAP: SCS=0 for SK_DIV cycles (tCS min), then IDLE.
- Bit timing:
  - Each bit lasts 2*SK_DIV cycles: SSK=0 for the first half, SSK=1 for the second.
  - SDI changes only at bit start (SK low).
  - SDO is sampled on the clk edge where SSK rises, using the synchronised value.
  - The 2-flop synchroniser delay requires SK_DIV >= 2 for a correct read at full speed. SK_DIV = 1 is legal only with a device that holds DO for a full bit.
- A request arriving during START..GAP (for example, the CPU retries with a new address) has WAIT asserted. It is evaluated in IDLE.
  - If the finished read matches BA, the next IDLE cycle is a hit. SDRD is valid and WAIT drops.
  - If it does not match, a new transaction starts.
- BA changing mid-transaction does not affect areg.
- ERR is cleared only by rst.

## Timing
- Reset values (async):
  - State IDLE.
  - SCS=0, SSK=0, SDI=0.
  - vld=0, tag=0, dat=0, ERR=0.
  - SDRD=0; WAIT follows win_rd.
- Reset mid-transaction drops SCS in the same instant and invalidates the cache.
- Let a miss be seen in IDLE at edge N:
  - START occupies N+1 .. N+SK_DIV.
  - CMD bits occupy 20*SK_DIV cycles, DUMMY 2*SK_DIV, DATA 16*SK_DIV.
  - DONE is at edge N+1+39*SK_DIV (N+79 for SK_DIV=2).
  - GAP follows; IDLE is at N+2+40*SK_DIV.
- WAIT stays high from the miss through GAP while win_rd is held.
- First hit service: edge N+2+40*SK_DIV.
- A hit in IDLE produces 0 cycles of stall.

## Test plan
1. Reset, then read BA=4'h5 with an EEPROM model returning 8'hA7 (SK_DIV=2):
   - SDI sequence is 1,1,0,0,0,0,0,1,0,1.
   - WAIT is high for 81 cycles.
   - SDRD=8'hA7 at the first IDLE cycle, ERR=0.
2. Repeat a read of BA=4'h5:
   - WAIT is never asserted.
   - SDRD=8'hA7 in the same cycle.
   - SCS stays 0.
3. Read BA=4'h9 (model returns 8'h3C), then BA=4'h5:
   - Two full serial transactions.
   - The cache ends with tag=9 after the first and tag=5 after the second.
   - SDRD values are 3C, then A7.
4. Model drives 1 on the dummy bit for BA=4'h2:
   - ERR=1 and vld stays 0.
   - The retried read starts a new transaction.
   - ERR remains 1.
5. Assert rst during DATA bit 3:
   - SCS=0 and SSK=0 immediately; SDRD=0.
   - The next read of BA=4'h5 performs a full serial transaction.
6. Window write (BR_W=0) and a BA13=1 access, each held 10 cycles:
   - No WAIT, no SCS activity, SDRD=0.
